controller_digit_entry: RTL

Parametrised number-entry unit for the calculator controller. It replaces the one-digit-per-command decode with a sequential digit accumulator: it takes keypad commands while the controller is in `CS_PARSE` and maintains a live signed operand. Radix is configurable up to 16, with backspace, sign toggle, clear and commit. Its output feeds the existing number register (`number_D`/`number_EN`) and the display path.

---
 rtl/controller_digit_entry_pkg.sv | 39 +++
 rtl/controller_digit_entry_if.sv | 24 ++
 rtl/controller_digit_entry_digit_mac.sv | 34 +++
 rtl/controller_digit_entry.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/controller_digit_entry_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : controller_digit_entry_pkg
//  Purpose  : Shared encodings for the digit-entry unit: controller state
//             width and the parse state, keypad command codes, and the
//             digit-entry FSM states.
//  Revision : 1.0 - initial release
// ============================================================================
package controller_digit_entry_pkg;

    // Default operand width, controller state width (state bus is CS_N+1 bits)
    // and keypad command width.
    localparam int CD_N = 16;
    localparam int CS_N = 2;
    localparam int IC_N = 5;

    // Controller states seen on the state bus. Only CS_PARSE matters here.
    localparam logic [CS_N:0] CS_IDLE  = 3'd0;
    localparam logic [CS_N:0] CS_PARSE = 3'd2;
    localparam logic [CS_N:0] CS_EXEC  = 3'd3;

    // Keypad commands. Digit codes equal their digit value, so the low nibble
    // of any code <= IC_NUMF is the digit itself.
    localparam logic [IC_N-1:0] IC_NUM0  = 5'h00;
    localparam logic [IC_N-1:0] IC_NUMA  = 5'h0A;
    localparam logic [IC_N-1:0] IC_NUMF  = 5'h0F;
    localparam logic [IC_N-1:0] IC_BKSP  = 5'h10;
    localparam logic [IC_N-1:0] IC_NEG   = 5'h11;
    localparam logic [IC_N-1:0] IC_CLR   = 5'h12;
    localparam logic [IC_N-1:0] IC_ENTER = 5'h13;

    // Digit-entry FSM.
    typedef enum logic [0:0] {
        DE_IDLE    = 1'b0,
        DE_REBUILD = 1'b1
    } de_state_e;

endpackage
`default_nettype wire

// File: rtl/controller_digit_entry_if.sv
`default_nettype none
// ============================================================================
//  Module   : controller_digit_entry_if
//  Purpose  : Command handshake between the calculator controller (master)
//             and the digit-entry unit (slave).
//  Signals  : state     - controller state
//             in_cmd    - keypad command
//             cmd_valid - in_cmd is valid this cycle
//             cmd_ready - digit-entry unit can accept a command
//  Revision : 1.0 - initial release
// ============================================================================
interface controller_digit_entry_if;
    import controller_digit_entry_pkg::*;

    logic [CS_N:0]   state;
    logic [IC_N-1:0] in_cmd;
    logic            cmd_valid;
    logic            cmd_ready;

    modport master (output state, output in_cmd, output cmd_valid, input cmd_ready);
    modport slave  (input state, input in_cmd, input cmd_valid, output cmd_ready);

endinterface
`default_nettype wire

// File: rtl/controller_digit_entry_digit_mac.sv
`default_nettype none
// ============================================================================
//  Module   : digit_mac
//  Purpose  : Combinational multiply-accumulate mag*RADIX + digit, computed at
//             full precision, with a flag when the result does not fit in the
//             WIDTH-1 bit magnitude.
//  Ports    : i_mag      - current magnitude (WIDTH-1 bits, unsigned)
//             i_digit    - digit to append
//             o_result   - low WIDTH-1 bits of the result
//             o_overflow - result exceeds 2^(WIDTH-1)-1
//  Revision : 1.0 - initial release
// ============================================================================
module digit_mac #(
    parameter int RADIX = 10,
    parameter int WIDTH = 16
) (
    input  wire logic [WIDTH-2:0] i_mag,
    input  wire logic [3:0]       i_digit,
    output logic      [WIDTH-2:0] o_result,
    output logic                  o_overflow
);

    // RADIX <= 16 adds at most 4 bits to the product and the digit one more.
    localparam int              C_PW    = WIDTH + 5;
    localparam logic [C_PW-1:0] C_RADIX = C_PW'(RADIX);

    logic [C_PW-1:0] w_full;

    assign w_full     = C_PW'(i_mag) * C_RADIX + C_PW'(i_digit);
    assign o_result   = w_full[WIDTH-2:0];
    assign o_overflow = |w_full[C_PW-1:WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/controller_digit_entry.sv
`default_nettype none
// ============================================================================
//  Module   : controller_digit_entry
//  Purpose  : Sequential digit accumulator for the calculator controller.
//             Builds a signed operand from keypad commands in CS_PARSE with
//             backspace, sign toggle, clear and commit.
//  Ports    : Clock, Reset (async, active low)
//             cmd_if      - command handshake (slave side)
//             live_Q      - current signed value for the display
//             digit_count - digits held in the buffer
//             number_D    - committed operand
//             number_EN   - one-cycle load strobe for number_D
//             err         - one-cycle pulse on a rejected digit
//  Revision : 1.0 - initial release
// ============================================================================
module controller_digit_entry
    import controller_digit_entry_pkg::*;
#(
    parameter int RADIX      = 10,
    parameter int WIDTH      = CD_N,
    parameter int MAX_DIGITS = 8
) (
    input  wire logic             Clock,
    input  wire logic             Reset,
    controller_digit_entry_if.slave cmd_if,
    output logic      [WIDTH-1:0] live_Q,
    output logic      [4:0]       digit_count,
    output logic      [WIDTH-1:0] number_D,
    output logic                  number_EN,
    output logic                  err
);

    localparam logic [4:0] C_RADIX = 5'(RADIX);
    localparam logic [4:0] C_MAX   = 5'(MAX_DIGITS);

    de_state_e        fsm_q, fsm_d;
    logic [4:0]       count_q, count_d;
    logic [WIDTH-2:0] mag_q, mag_d;
    logic             neg_q, neg_d;
    logic [3:0]       idx_q, idx_d;
    logic [WIDTH-1:0] num_q, num_d;
    logic             number_en_q, number_en_d;
    logic             err_q, err_d;

    // Fixed 16-entry buffer keeps the index a plain 4-bit value for any
    // MAX_DIGITS; entries at or above MAX_DIGITS are never written.
    logic [3:0]       digit_buf_q [16];
    logic             buf_we;

    logic             w_is_digit;
    logic [3:0]       w_digit;
    logic             w_ready;
    logic             w_accept;
    logic [3:0]       w_mac_digit;
    logic [WIDTH-2:0] w_mac_result;
    logic             w_mac_ovf;
    logic [WIDTH-1:0] w_mag_ext;
    logic [WIDTH-1:0] w_live;

    // Inline command decoder: digit codes carry their value in the low nibble.
    assign w_is_digit = (cmd_if.in_cmd <= IC_NUMF);
    assign w_digit    = cmd_if.in_cmd[3:0];

    // CLR must be able to abort a rebuild, so it is the one command that sees
    // ready while the FSM is busy.
    assign w_ready          = (fsm_q == DE_IDLE) || (cmd_if.in_cmd == IC_CLR);
    assign cmd_if.cmd_ready = w_ready;
    assign w_accept         = cmd_if.cmd_valid && w_ready && (cmd_if.state == CS_PARSE);

    // One MAC serves both the live digit path and the rebuild walk.
    assign w_mac_digit = (fsm_q == DE_REBUILD) ? digit_buf_q[idx_q] : w_digit;

    digit_mac #(
        .RADIX (RADIX),
        .WIDTH (WIDTH)
    ) u_mac (
        .i_mag      (mag_q),
        .i_digit    (w_mac_digit),
        .o_result   (w_mac_result),
        .o_overflow (w_mac_ovf)
    );

    assign w_mag_ext = {1'b0, mag_q};
    assign w_live    = neg_q ? -w_mag_ext : w_mag_ext;

    always_comb begin
        fsm_d       = fsm_q;
        count_d     = count_q;
        mag_d       = mag_q;
        neg_d       = neg_q;
        idx_d       = idx_q;
        num_d       = num_q;
        number_en_d = 1'b0;
        err_d       = 1'b0;
        buf_we      = 1'b0;

        // Rebuild: mag was zeroed on the BKSP edge; fold in one stored digit
        // per cycle and leave after the last one (or at once if none remain).
        // This runs regardless of the controller state.
        if (fsm_q == DE_REBUILD) begin
            if ({1'b0, idx_q} < count_q) begin
                mag_d = w_mac_result;
                idx_d = idx_q + 4'd1;
            end
            if (({1'b0, idx_q} + 5'd1) >= count_q) begin
                fsm_d = DE_IDLE;
            end
        end

        if (w_accept) begin
            case (cmd_if.in_cmd)
                IC_CLR: begin
                    count_d = 5'd0;
                    mag_d   = '0;
                    neg_d   = 1'b0;
                    fsm_d   = DE_IDLE;
                end
                IC_ENTER: begin
                    num_d       = w_live;
                    number_en_d = 1'b1;
                    count_d     = 5'd0;
                    mag_d       = '0;
                    neg_d       = 1'b0;
                end
                IC_NEG: begin
                    // No sign on zero, so -0 can never be displayed.
                    if (mag_q != '0) begin
                        neg_d = ~neg_q;
                    end
                end
                IC_BKSP: begin
                    if (count_q != 5'd0) begin
                        count_d = count_q - 5'd1;
                        mag_d   = '0;
                        idx_d   = 4'd0;
                        fsm_d   = DE_REBUILD;
                    end
                end
                default: begin
                    if (w_is_digit) begin
                        if (({1'b0, w_digit} >= C_RADIX) || (count_q == C_MAX) || w_mac_ovf) begin
                            err_d = 1'b1;
                        end else if (!((count_q == 5'd0) && (w_digit == 4'd0))) begin
                            // Leading zeros change nothing and use no buffer slot.
                            buf_we  = 1'b1;
                            count_d = count_q + 5'd1;
                            mag_d   = w_mac_result;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            fsm_q       <= DE_IDLE;
            count_q     <= 5'd0;
            mag_q       <= '0;
            neg_q       <= 1'b0;
            idx_q       <= 4'd0;
            num_q       <= '0;
            number_en_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            count_q     <= count_d;
            mag_q       <= mag_d;
            neg_q       <= neg_d;
            idx_q       <= idx_d;
            num_q       <= num_d;
            number_en_q <= number_en_d;
            err_q       <= err_d;
        end
    end

    // Buffer contents are don't-care after reset, so no reset term here.
    always_ff @(posedge Clock) begin
        if (buf_we) begin
            digit_buf_q[count_q[3:0]] <= w_digit;
        end
    end

    assign live_Q      = w_live;
    assign digit_count = count_q;
    assign number_D    = num_q;
    assign number_EN   = number_en_q;
    assign err         = err_q;

endmodule
`default_nettype wire
